decode_cycle: RTL and testbench

//  ID stage of the 5-stage RV32I pipeline; consumes InstrD/PCD/PCPlus4D from fetch_cycle.

---
 rtl/decode_cycle.sv | 161 ++++++++++++++++
 tb/tb_decode_cycle.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// ID stage: 32x32 register file (write-first bypass), control/ALU decode, immediate sign-extension.
// One-cycle latency into the ID/EX register; no stall path, FlushE zeroes only the control fields.
module decode_cycle #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [REG_AW-1:0] RS1_E,
  output logic [REG_AW-1:0] RS2_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
);

  localparam int NREG = 2 ** REG_AW;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } idex_t;

  logic [XLEN-1:0]   rf_q [NREG];
  logic [XLEN-1:0]   rf_d [NREG];
  logic [REG_AW-1:0] rs1, rs2;
  logic [XLEN-1:0]   rd1, rd2;
  logic              wr_en;
  ctrl_t             ctrl;
  logic [XLEN-1:0]   imm;
  idex_t             idex_d, idex_q;

  assign rs1   = InstrD[19:15];
  assign rs2   = InstrD[24:20];
  assign wr_en = RegWriteW && (RDW != '0);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[RDW] = ResultW;
  end

  // Same-cycle writeback is forwarded so the decoded operand is never stale.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (wr_en && RDW == rs1) ? ResultW : rf_q[rs1];
    if (rs2 != '0) rd2 = (wr_en && RDW == rs2) ? ResultW : rf_q[rs2];
  end

  always_comb begin
    ctrl = '0;
    imm  = '0;
    unique case (InstrD[6:0])
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
        imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R, OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = (InstrD[6:0] == OP_IALU);
        if (InstrD[6:0] == OP_IALU) imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
        case (InstrD[14:12])
          3'b000:  ctrl.alu_ctrl = (InstrD[6:0] == OP_R && InstrD[30]) ? 3'b001 : 3'b000;
          3'b111:  ctrl.alu_ctrl = 3'b010;
          3'b110:  ctrl.alu_ctrl = 3'b011;
          3'b010:  ctrl.alu_ctrl = 3'b101;
          default: ctrl.alu_ctrl = 3'b000;
        endcase
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = 3'b001;
        imm = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    idex_d          = '0;
    idex_d.ctrl     = FlushE ? '0 : ctrl;
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.imm      = imm;
    idex_d.rs1      = rs1;
    idex_d.rs2      = rs2;
    idex_d.rd       = InstrD[11:7];
    idex_d.pc       = PCD;
    idex_d.pc_plus4 = PCPlus4D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      idex_q <= '0;
    end else begin
      rf_q   <= rf_d;
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUControlE = idex_q.ctrl.alu_ctrl;
  assign RD1_E       = idex_q.rd1;
  assign RD2_E       = idex_q.rd2;
  assign Imm_Ext_E   = idex_q.imm;
  assign RS1_E       = idex_q.rs1;
  assign RS2_E       = idex_q.rs2;
  assign RD_E        = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed scenarios plus randomized instructions against a reference model.
module tb_decode_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RS1_E, RS2_E, RD_E;

  int total  = 0;
  int passed = 0;
  logic [31:0]  ref_rf [32];
  logic [182:0] exp_v;
  logic [182:0] mask_v;
  logic [182:0] got;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E),
    .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  assign got = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E};

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (RegWriteW && RDW == r) return ResultW;
    return ref_rf[r];
  endfunction

  // Expected ID/EX contents for the instruction currently presented.
  function automatic logic [182:0] model();
    logic [6:0]  op;
    logic        rw, as, mw, rs, br;
    logic [2:0]  alu;
    logic [31:0] imm, i_imm, s_imm, b_imm;
    op = InstrD[6:0];
    i_imm = $signed(InstrD) >>> 20;
    s_imm = $signed({InstrD[31:25], InstrD[11:7], 20'd0}) >>> 20;
    b_imm = $signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 20'd0}) >>> 19;
    {rw, as, mw, rs, br} = 5'b0;
    alu = 3'd0;
    imm = 32'd0;
    if (op == 7'h33 || op == 7'h13) begin
      rw = 1'b1;
      as = (op == 7'h13);
      imm = i_imm;
      case (InstrD[14:12])
        3'd0:    alu = (op == 7'h33 && InstrD[30]) ? 3'd1 : 3'd0;
        3'd7:    alu = 3'd2;
        3'd6:    alu = 3'd3;
        3'd2:    alu = 3'd5;
        default: alu = 3'd0;
      endcase
    end else if (op == 7'h03) begin
      rw = 1'b1; as = 1'b1; rs = 1'b1; imm = i_imm;
    end else if (op == 7'h23) begin
      mw = 1'b1; as = 1'b1; imm = s_imm;
    end else if (op == 7'h63) begin
      br = 1'b1; alu = 3'd1; imm = b_imm;
    end
    if (FlushE) begin
      {rw, as, mw, rs, br} = 5'b0;
      alu = 3'd0;
    end
    return {rw, as, mw, rs, br, alu, ref_read(InstrD[19:15]), ref_read(InstrD[24:20]),
            imm, InstrD[19:15], InstrD[24:20], InstrD[11:7], PCD, PCPlus4D};
  endfunction

  // Present one instruction plus writeback at the negedge; outputs are observable 1ns past the posedge.
  task automatic cycle(input logic [31:0] instr, input logic regw, input logic [4:0] rdw,
                       input logic [31:0] resw, input logic flush);
    logic [6:0] op;
    @(negedge clk);
    InstrD = instr; RegWriteW = regw; RDW = rdw; ResultW = resw; FlushE = flush;
    PCD = $urandom & 32'hFFFF_FFFC;
    PCPlus4D = PCD + 32'd4;
    #1;
    exp_v = model();
    op = instr[6:0];
    mask_v = '1;
    if (!(op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h63)) mask_v[110:79] = '0;
    if (regw && rdw != 5'd0) ref_rf[rdw] = resw;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; FlushE = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    #3;
    total++;
    if (got !== 183'd0) $display("FAIL reset_outputs got=%h want=0", got); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add();
    cycle(32'h0000_0013, 1'b1, 5'd5, 32'h0000_0007, 1'b0);
    cycle(32'h0053_02B3, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if ({RegWriteE, ALUControlE, RD2_E, RD_E} !== {1'b1, 3'b000, 32'd7, 5'd5})
      $display("FAIL add_fields got=%b/%b/%h/%0d want=1/000/7/5", RegWriteE, ALUControlE, RD2_E, RD_E);
    else passed++;
    total++;
    if ((got & mask_v) !== (exp_v & mask_v)) $display("FAIL add_model got=%h want=%h", got, exp_v);
    else passed++;
  endtask

  task automatic test_lw_bypass();
    cycle(32'hFFC4_2303, 1'b1, 5'd8, 32'h0000_0100, 1'b0);
    total++;
    if ({Imm_Ext_E, ResultSrcE, ALUSrcE} !== {32'hFFFF_FFFC, 1'b1, 1'b1})
      $display("FAIL lw_fields got=%h/%b/%b want=fffffffc/1/1", Imm_Ext_E, ResultSrcE, ALUSrcE);
    else passed++;
    total++;
    if (RD1_E !== 32'h0000_0100) $display("FAIL bypass_rd1 got=%h want=00000100", RD1_E); else passed++;
    total++;
    if (got !== exp_v) $display("FAIL lw_model got=%h want=%h", got, exp_v); else passed++;
  endtask

  task automatic test_x0();
    cycle(32'h0000_0013, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0);
    cycle(32'h0010_0093, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if (RD1_E !== 32'd0) $display("FAIL x0_read got=%h want=0", RD1_E); else passed++;
    cycle(32'h0000_0033, 1'b1, 5'd0, 32'h0000_BEEF, 1'b0);
    total++;
    if ({RD1_E, RD2_E} !== 64'd0) $display("FAIL x0_bypass got=%h/%h want=0/0", RD1_E, RD2_E); else passed++;
  endtask

  task automatic test_flush();
    cycle(32'h0020_8463, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if ({BranchE, ALUControlE, Imm_Ext_E} !== {1'b1, 3'b001, 32'd8})
      $display("FAIL beq_fields got=%b/%b/%h want=1/001/8", BranchE, ALUControlE, Imm_Ext_E);
    else passed++;
    cycle(32'h0020_8463, 1'b0, 5'd0, 32'h0, 1'b1);
    total++;
    if ({BranchE, RegWriteE, MemWriteE, ALUControlE} !== 6'd0 || RS2_E !== 5'd2)
      $display("FAIL flush_ctrl got=%b%b%b/%b rs2=%0d want=000/000 rs2=2", BranchE, RegWriteE, MemWriteE, ALUControlE, RS2_E);
    else passed++;
    cycle(32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if ({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE} !== 8'd0)
      $display("FAIL bad_opcode_ctrl got=%b want=0", {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE});
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0]  ops [6];
    logic [31:0] instr;
    int          errs;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h7F};
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      instr[6:0] = (n % 9 == 8) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      cycle(instr, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
      total++;
      if ((got & mask_v) !== (exp_v & mask_v)) begin
        if (errs < 5) $display("FAIL random_%0d instr=%h got=%h want=%h", n, instr, got, exp_v);
        errs++;
      end else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cycle(32'h0000_0013, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
    cycle(32'h0053_02B3, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if (RD2_E !== 32'h0000_1234) $display("FAIL preload_x5 got=%h want=00001234", RD2_E); else passed++;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (got !== 183'd0) $display("FAIL midrun_reset got=%h want=0", got); else passed++;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    cycle(32'h0053_02B3, 1'b0, 5'd0, 32'h0, 1'b0);
    total++;
    if (RD2_E !== 32'd0) $display("FAIL x5_after_reset got=%h want=0", RD2_E); else passed++;
    total++;
    if ((got & mask_v) !== (exp_v & mask_v)) $display("FAIL after_reset_model got=%h want=%h", got, exp_v);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_bypass();
    test_x0();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
